// File: rtl/sdp_sync_fifo.sv
// Single-clock FIFO over a simple-dual-port RAM: occupancy count, registered threshold flags, OVF/UDF pulses.
// Read latency 1 cycle (RD/RVALID after accepting edge); WEN while FULL / REN while EMPTY are dropped and flagged, never stalled.
module sdp_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 2048,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     CLK,
  input  logic                     ARST_N,
  input  logic                     CLR,
  input  logic [WIDTH-1:0]         WD,
  input  logic                     WEN,
  input  logic                     REN,
  output logic [WIDTH-1:0]         RD,
  output logic                     RVALID,
  output logic                     FULL,
  output logic                     AFULL,
  output logic                     EMPTY,
  output logic                     AEMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVF,
  output logic                     UDF
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             empty_q, empty_d;
  logic             aempty_q, aempty_d;
  logic             rvalid_q, rvalid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] rd_q;
  logic             wr_acc, rd_acc;

  // Acceptance uses this cycle's registered flags only, so a full FIFO
  // rejects a write even when a read frees a slot on the same edge.
  always_comb begin
    wr_acc = WEN & ~full_q  & ~CLR;
    rd_acc = REN & ~empty_q & ~CLR;
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rvalid_d = rd_acc;
    ovf_d    = WEN & full_q  & ~CLR;
    udf_d    = REN & empty_q & ~CLR;

    if (CLR) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (rd_acc) rptr_d = rptr_q + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end

    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wptr_q] <= WD;
  end

  // Registered read port. Accepted read and write never share an address
  // (that needs COUNT of 0 or DEPTH), so no bypass path is required.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      rd_q <= '0;
    end else if (rd_acc) begin
      rd_q <= mem[rptr_q];
    end
  end

  assign RD     = rd_q;
  assign RVALID = rvalid_q;
  assign FULL   = full_q;
  assign AFULL  = afull_q;
  assign EMPTY  = empty_q;
  assign AEMPTY = aempty_q;
  assign COUNT  = count_q;
  assign OVF    = ovf_q;
  assign UDF    = udf_q;

endmodule

// File: tb/tb_sdp_sync_fifo.sv
// Directed vector bench for sdp_sync_fifo at DEPTH=16, WIDTH=8, AF_LEVEL=12, AE_LEVEL=4.
module tb_sdp_sync_fifo;

  logic       CLK;
  logic       ARST_N;
  logic       CLR;
  logic [7:0] WD;
  logic       WEN;
  logic       REN;
  logic [7:0] RD;
  logic       RVALID, FULL, AFULL, EMPTY, AEMPTY, OVF, UDF;
  logic [4:0] COUNT;

  int total = 0;
  int bad   = 0;

  sdp_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .CLK(CLK), .ARST_N(ARST_N), .CLR(CLR), .WD(WD), .WEN(WEN), .REN(REN),
    .RD(RD), .RVALID(RVALID), .FULL(FULL), .AFULL(AFULL), .EMPTY(EMPTY),
    .AEMPTY(AEMPTY), .COUNT(COUNT), .OVF(OVF), .UDF(UDF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       wen, ren, clr;
    logic [7:0] wd;
    logic [4:0] cnt;
    logic       empty, full, afull, aempty, ovf, udf, rvalid;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int wen, input int ren, input int clr, input int wd,
                              input int cnt, input int empty, input int full, input int afull,
                              input int aempty, input int ovf, input int udf, input int rvalid,
                              input int rd);
    vec_t v;
    v.wen = 1'(wen); v.ren = 1'(ren); v.clr = 1'(clr); v.wd = 8'(wd);
    v.cnt = 5'(cnt); v.empty = 1'(empty); v.full = 1'(full); v.afull = 1'(afull);
    v.aempty = 1'(aempty); v.ovf = 1'(ovf); v.udf = 1'(udf); v.rvalid = 1'(rvalid);
    v.rd = 8'(rd);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input int cnt, input int empty, input int full,
                         input int afull, input int aempty, input int ovf, input int udf,
                         input int rvalid, input int rd);
    chk("count",  idx, 32'(COUNT),  32'(cnt));
    chk("empty",  idx, 32'(EMPTY),  32'(empty));
    chk("full",   idx, 32'(FULL),   32'(full));
    chk("afull",  idx, 32'(AFULL),  32'(afull));
    chk("aempty", idx, 32'(AEMPTY), 32'(aempty));
    chk("ovf",    idx, 32'(OVF),    32'(ovf));
    chk("udf",    idx, 32'(UDF),    32'(udf));
    chk("rvalid", idx, 32'(RVALID), 32'(rvalid));
    chk("rd",     idx, 32'(RD),     32'(rd));
  endtask

  initial begin
    // Fill 1..16: flags follow the count after each edge.
    for (int i = 1; i <= 16; i++)
      add(1, 0, 0, i, i, 0, int'(i == 16), int'(i >= 12), int'(i <= 4), 0, 0, 0, 0);
    add(1, 0, 0, 8'h11, 16, 0, 1, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0,     16, 0, 1, 1, 0, 0, 0, 0, 0);
    // Drain: RD shows 1..16, RVALID every cycle.
    for (int j = 1; j <= 16; j++)
      add(0, 1, 0, 0, 16 - j, int'(j == 16), 0, int'(16 - j >= 12), int'(16 - j <= 4), 0, 0, 1, j);
    add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 8'h10);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 8'h10);
    // Fill to 8, then 40 simultaneous write/read cycles, then drain.
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 8'h20 + i, i + 1, 0, 0, 0, int'(i + 1 <= 4), 0, 0, 0, 8'h10);
    for (int k = 0; k < 40; k++)
      add(1, 1, 0, 8'h28 + k, 8, 0, 0, 0, 0, 0, 0, 1, 8'h20 + k);
    for (int m = 0; m < 8; m++)
      add(0, 1, 0, 0, 7 - m, int'(m == 7), 0, 0, int'(7 - m <= 4), 0, 0, 1, 8'h48 + m);
    // Single word then read next cycle; then read in the same cycle as a write into empty.
    add(1, 0, 0, 8'hA5, 1, 0, 0, 0, 1, 0, 0, 0, 8'h4F);
    add(0, 1, 0, 0,     0, 1, 0, 0, 1, 0, 0, 1, 8'hA5);
    add(1, 1, 0, 8'h5A, 1, 0, 0, 0, 1, 0, 1, 0, 8'hA5);
    add(0, 1, 0, 0,     0, 1, 0, 0, 1, 0, 0, 1, 8'h5A);
    // Fill 10, flush with WEN+REN also high, then fresh data only.
    for (int i = 0; i < 10; i++)
      add(1, 0, 0, 8'h60 + i, i + 1, 0, 0, 0, int'(i + 1 <= 4), 0, 0, 0, 8'h5A);
    add(1, 1, 1, 8'h77, 0, 1, 0, 0, 1, 0, 0, 0, 8'h5A);
    add(1, 0, 0, 8'h88, 1, 0, 0, 0, 1, 0, 0, 0, 8'h5A);
    add(0, 1, 0, 0,     0, 1, 0, 0, 1, 0, 0, 1, 8'h88);
    add(0, 0, 0, 0,     0, 1, 0, 0, 1, 0, 0, 0, 8'h88);

    ARST_N = 1'b1; CLR = 1'b0; WD = '0; WEN = 1'b0; REN = 1'b0;
    #1 ARST_N = 1'b0;
    #1 chk_all(-1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    @(negedge CLK);
    ARST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      WEN = vecs[i].wen; REN = vecs[i].ren; CLR = vecs[i].clr; WD = vecs[i].wd;
      @(negedge CLK);
      chk_all(i, vecs[i].cnt, vecs[i].empty, vecs[i].full, vecs[i].afull, vecs[i].aempty,
              vecs[i].ovf, vecs[i].udf, vecs[i].rvalid, vecs[i].rd);
    end
    WEN = 1'b0; REN = 1'b0; CLR = 1'b0;

    // Asynchronous reset in the middle of a write burst at COUNT=7.
    for (int i = 0; i < 7; i++) begin
      WEN = 1'b1; WD = 8'h90 + 8'(i);
      @(posedge CLK);
      #1;
    end
    chk("burst_count", 0, 32'(COUNT), 32'd7);
    #1 ARST_N = 1'b0;
    #1 chk_all(1000, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    @(negedge CLK);
    chk_all(1001, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    WEN = 1'b0;
    ARST_N = 1'b1;
    WEN = 1'b1; WD = 8'hC3;
    @(negedge CLK);
    chk_all(1002, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    WEN = 1'b0; REN = 1'b1;
    @(negedge CLK);
    chk_all(1003, 0, 1, 0, 0, 1, 0, 0, 1, 8'hC3);
    REN = 1'b0;
    @(negedge CLK);
    chk_all(1004, 0, 1, 0, 0, 1, 0, 0, 0, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
